// File: rtl/mem_port_arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_port_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arb_sel.sv
// Winner selection between fetch and data requesters, with a bounded data streak
// so a pending fetch is served after at most D_STREAK_MAX consecutive data grants.
module mem_port_arb_sel
  import mem_port_arb_pkg::*;
#(
  parameter int D_STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  input  logic gnt_stb,
  output logic sel_d
);

  localparam int SW = $clog2(D_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(D_STREAK_MAX);

  logic [SW-1:0] streak_r;
  logic          at_max_s;

  // Data wins unless the streak is exhausted while fetch is also waiting.
  always_comb begin
    at_max_s = 1'b0;
    sel_d    = 1'b0;
    at_max_s = (streak_r == STREAK_SAT);
    sel_d    = d_req & ~(if_req & at_max_s);
  end

  // Streak counter: counts data grants that made fetch wait, cleared by any fetch grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_r <= {SW{1'b0}};
    end else if (gnt_stb) begin
      if (!sel_d) begin
        streak_r <= {SW{1'b0}};
      end else if (if_req && !at_max_s) begin
        streak_r <= streak_r + {{(SW-1){1'b0}}, 1'b1};
      end else begin
        streak_r <= streak_r;
      end
    end else begin
      streak_r <= streak_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data requesters onto one shared memory port, one transaction at a time.
// Optional performance counters are enabled by defining MEM_PORT_ARB_PERF_EN.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int D_STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err_unexp
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]         perf_if_grants,
  output logic [31:0]         perf_d_grants,
  output logic [31:0]         perf_wait_cycles
`endif
);

  localparam int BE_W = DATA_W / 8;

  state_t              state_r, state_nx_s;
  owner_t              owner_r;
  logic                gnt_stb_s, sel_d_s, rsp_hit_s;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [BE_W-1:0]     be_r;
  logic                if_rvalid_r, d_rvalid_r, err_unexp_r;
  logic [DATA_W-1:0]   if_rdata_r, d_rdata_r;

  mem_port_arb_sel #(
    .D_STREAK_MAX (D_STREAK_MAX)
  ) u_sel (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (if_req),
    .d_req   (d_req),
    .gnt_stb (gnt_stb_s),
    .sel_d   (sel_d_s)
  );

  // Next-state and grant decode; grants are combinational so a request is taken in its first IDLE cycle.
  always_comb begin
    state_nx_s = state_r;
    gnt_stb_s  = 1'b0;
    rsp_hit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req || d_req) begin
          gnt_stb_s  = 1'b1;
          state_nx_s = REQ;
        end else begin
          state_nx_s = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_nx_s = RSP;
        end else begin
          state_nx_s = REQ;
        end
      end
      RSP: begin
        if (mem_rvalid) begin
          rsp_hit_s  = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RSP;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Request latch: fields stay frozen from grant until the next grant, covering all of REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= OWN_NONE;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      be_r    <= {BE_W{1'b0}};
    end else if (gnt_stb_s) begin
      if (sel_d_s) begin
        owner_r <= OWN_D;
        we_r    <= d_we;
        addr_r  <= d_addr;
        wdata_r <= d_wdata;
        be_r    <= d_be;
      end else begin
        owner_r <= OWN_IF;
        we_r    <= 1'b0;
        addr_r  <= if_addr;
        wdata_r <= {DATA_W{1'b0}};
        be_r    <= {BE_W{1'b1}};
      end
    end else if (rsp_hit_s) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= owner_r;
    end
  end

  // Response routing to the owner, plus flagging responses that arrive outside RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      err_unexp_r <= 1'b0;
      if_rdata_r  <= {DATA_W{1'b0}};
      d_rdata_r   <= {DATA_W{1'b0}};
    end else begin
      if_rvalid_r <= rsp_hit_s && (owner_r == OWN_IF);
      d_rvalid_r  <= rsp_hit_s && (owner_r == OWN_D);
      err_unexp_r <= mem_rvalid && (state_r != RSP);
      if (rsp_hit_s && (owner_r == OWN_IF)) begin
        if_rdata_r <= mem_rdata;
      end
      if (rsp_hit_s && (owner_r == OWN_D)) begin
        d_rdata_r <= mem_rdata;
      end
    end
  end

  assign if_gnt    = gnt_stb_s & ~sel_d_s;
  assign d_gnt     = gnt_stb_s & sel_d_s;
  assign mem_req   = (state_r == REQ);
  assign busy      = (state_r != IDLE);
  assign mem_we    = we_r & (state_r == REQ);
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_be    = be_r;
  assign if_rvalid = if_rvalid_r;
  assign d_rvalid  = d_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign err_unexp = err_unexp_r;

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_if_r, perf_d_r, perf_wait_r;
  logic        wait_s;

  assign wait_s = (if_req & ~if_gnt) | (d_req & ~d_gnt);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_r   <= 32'd0;
      perf_d_r    <= 32'd0;
      perf_wait_r <= 32'd0;
    end else begin
      if (if_gnt && (perf_if_r != 32'hFFFF_FFFF)) begin
        perf_if_r <= perf_if_r + 32'd1;
      end
      if (d_gnt && (perf_d_r != 32'hFFFF_FFFF)) begin
        perf_d_r <= perf_d_r + 32'd1;
      end
      if (wait_s && (perf_wait_r != 32'hFFFF_FFFF)) begin
        perf_wait_r <= perf_wait_r + 32'd1;
      end
    end
  end

  assign perf_if_grants   = perf_if_r;
  assign perf_d_grants    = perf_d_r;
  assign perf_wait_cycles = perf_wait_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: expected responses are queued at grant and checked at rvalid.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy, err_unexp;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_wait_cycles;
`endif

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_d_grants = 0;
  int   model_if_grants = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_be       (d_be),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .err_unexp  (err_unexp)
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    .perf_if_grants   (perf_if_grants),
    .perf_d_grants    (perf_d_grants),
    .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle where the grant is expected, with requests already settled.
  // Ends in the IDLE cycle that carries the response pulse.
  task automatic do_txn(input bit exp_d, input logic [31:0] addr, input bit exp_we,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input int delay, input bit drop);
    exp_t e;
    chk("if_gnt", 64'(if_gnt), 64'(!exp_d));
    chk("d_gnt", 64'(d_gnt), 64'(exp_d));
    if (exp_d) model_d_grants++;
    else model_if_grants++;
    sb.push_back('{exp_d, addr + 32'h3});
    step();
    if (drop) begin
      if (exp_d) d_req = 1'b0;
      else if_req = 1'b0;
    end
    for (int i = 0; i <= delay; i++) begin
      #1;
      chk("mem_req", 64'(mem_req), 64'd1);
      chk("mem_addr", 64'(mem_addr), 64'(addr));
      chk("busy_req", 64'(busy), 64'd1);
      chk("gnt_in_req", 64'({if_gnt, d_gnt}), 64'd0);
      if (i == 0) begin
        chk("mem_we", 64'(mem_we), 64'(exp_we));
        chk("mem_be", 64'(mem_be), 64'(exp_be));
      end
      if (exp_d && i == 0) chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
      if (i == delay) mem_gnt = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
    #1;
    chk("mem_req_rsp", 64'(mem_req), 64'd0);
    chk("busy_rsp", 64'(busy), 64'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = addr + 32'h3;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    #1;
    e = sb.pop_front();
    chk("if_rvalid", 64'(if_rvalid), 64'(!e.is_d));
    chk("d_rvalid", 64'(d_rvalid), 64'(e.is_d));
    if (e.is_d) chk("d_rdata", 64'(d_rdata), 64'(e.data));
    else chk("if_rdata", 64'(if_rdata), 64'(e.data));
    chk("err_unexp_ok", 64'(err_unexp), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    bit exp_d;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    step();
    step();
    chk("rst_ctrl", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, busy, err_unexp}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    rst_n = 1'b1;
    step();

    // Lone fetch.
    if_addr = 32'h0000_0010; if_req = 1'b1;
    #1;
    do_txn(1'b0, 32'h10, 1'b0, 4'hF, 32'h0, 0, 1'b1);
    step();

    // Simultaneous requests: data first, fetch in the rvalid cycle.
    d_addr = 32'h20; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
    if_addr = 32'h14; if_req = 1'b1;
    #1;
    do_txn(1'b1, 32'h20, 1'b0, 4'hF, 32'h0, 0, 1'b1);
    do_txn(1'b0, 32'h14, 1'b0, 4'hF, 32'h0, 0, 1'b1);
    step();

    // Both held: D,D,D,D,IF,D,D,D,D,IF then drain (D, then lone IF).
    if_addr = 32'h100; if_req = 1'b1;
    d_addr = 32'h200; d_req = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      exp_d = (k < 10) ? ((k % 5) != 4) : (k == 10);
      do_txn(exp_d, exp_d ? 32'h200 : 32'h100, 1'b0, 4'hF, 32'h0, 0, (k >= 10));
    end
    step();

    // Memory grant delayed by three cycles.
    d_addr = 32'h300; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
    #1;
    do_txn(1'b1, 32'h300, 1'b0, 4'hF, 32'h0, 3, 1'b1);
    step();

    // Partial store.
    d_addr = 32'h400; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    #1;
    do_txn(1'b1, 32'h400, 1'b1, 4'b0011, 32'hDEAD_BEEF, 0, 1'b1);
    d_we = 1'b0;
`ifdef MEM_PORT_ARB_PERF_EN
    chk("perf_d_grants", 64'(perf_d_grants), 64'(model_d_grants));
    chk("perf_if_grants", 64'(perf_if_grants), 64'(model_if_grants));
`endif
    step();

    // Reset while in RSP, then a late response.
    d_addr = 32'h500; d_be = 4'hF; d_req = 1'b1;
    #1;
    chk("rst_txn_d_gnt", 64'(d_gnt), 64'd1);
    step();
    d_req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #1;
    chk("rst_txn_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, busy, err_unexp}), 64'd0);
    chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    model_d_grants = 0; model_if_grants = 0;
`ifdef MEM_PORT_ARB_PERF_EN
    chk("mid_rst_perf", 64'({perf_if_grants, perf_d_grants}), 64'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h503;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("late_err_unexp", 64'(err_unexp), 64'd1);
    chk("late_no_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    chk("late_d_rdata", 64'(d_rdata), 64'd0);
    step();
    chk("late_err_once", 64'(err_unexp), 64'd0);

    // Recovery after reset.
    if_addr = 32'h600; if_req = 1'b1;
    #1;
    do_txn(1'b0, 32'h600, 1'b0, 4'hF, 32'h0, 1, 1'b1);
    step();
    chk("final_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one unified memory port between the core's instruction-fetch requester and its data load/store requester. The core moves from separate IMEM/DMEM to a single memory. The block accepts one request at a time, forwards it to the shared port, waits for the response, and returns it to the owning requester. Data has priority over fetch, with a bounded-streak rule so fetch cannot starve. It sits between the core datapath (PC/fetch and load/store paths) and the shared memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte-enable width = DATA_W/8)
- D_STREAK_MAX, 4, maximum consecutive data grants while fetch is pending (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- if_req / if_addr  in  1 / ADDR_W  fetch request; held until if_gnt
- if_gnt  out  1  one-cycle pulse: fetch request latched
- if_rvalid / if_rdata  out  1 / DATA_W  fetch response, one-cycle pulse
- d_req / d_we / d_addr / d_wdata / d_be  in  1 / 1 / ADDR_W / DATA_W / DATA_W/8  data request; held until d_gnt
- d_gnt  out  1  one-cycle pulse: data request latched
- d_rvalid / d_rdata  out  1 / DATA_W  data response, one-cycle pulse (also the write ack)
- mem_req / mem_we / mem_addr / mem_wdata / mem_be  out  shared-port request, held until mem_gnt
- mem_gnt  in  1  memory accepts request
- mem_rvalid / mem_rdata  in  1 / DATA_W  memory response, earliest the cycle after mem_gnt
- busy  out  1  high when state ≠ IDLE
- err_unexp  out  1  one-cycle pulse: mem_rvalid received outside RSP

## Operation
- FSM states: IDLE, REQ, RSP. Owner register: NONE / IF / D.
- IDLE, with any x_req:
  - Select the winner.
  - Latch its addr/we/wdata/be. A fetch is latched as we=0, be=all-ones.
  - Pulse x_gnt in the same cycle (gnt is combinational on state and req).
  - Go to REQ.
- Selection: data wins, unless d_req & if_req & streak == D_STREAK_MAX, in which case fetch wins.
- Streak counter:
  - +1 on a data grant made while if_req is high.
  - Clears on any fetch grant.
  - Holds otherwise; saturates at D_STREAK_MAX.
  - Width $clog2(D_STREAK_MAX+1).
- REQ: mem_req=1 with the latched fields. On mem_gnt, go to RSP.
- RSP: on mem_rvalid, capture mem_rdata into the owner's rdata register, pulse x_rvalid next cycle, and go to IDLE.
- mem_rvalid in IDLE or REQ is ignored for data purposes and pulses err_unexp next cycle.
- x_rdata holds its last value between responses.
- Requester may drop x_req only after x_gnt. A new request raised in the same cycle as x_rvalid is arbitrated in that IDLE cycle.
- Reset outputs: all gnt/rvalid/mem_req/mem_we/busy/err_unexp = 0; mem_addr/wdata/be, rdata = 0; state IDLE, owner NONE, streak 0.
- Reset mid-transaction: the outstanding transaction is abandoned with no x_rvalid. A late mem_rvalid after reset raises err_unexp.

## Timing
- Best case: x_gnt at T, mem_req at T+1 (mem_gnt at T+1), mem_rvalid at T+2, x_rvalid at T+3. The next x_gnt is possible at T+3.
- Throughput: one transaction per ≥3 cycles.
- mem_req fields are stable from REQ entry until the mem_gnt cycle inclusive.
- mem_gnt with mem_req=0 is ignored.
- mem_gnt and mem_rvalid in the same REQ cycle: mem_gnt is taken and mem_rvalid is treated as unexpected (protocol forbids this case).

## Configuration
- MEM_PORT_ARB_PERF_EN defined:
  - Adds outputs perf_if_grants, perf_d_grants, perf_wait_cycles, each 32-bit and saturating.
  - perf_wait_cycles counts cycles where any x_req is high but x_gnt is low.
  - All counters reset to 0.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package mem_port_arb_pkg holds:
  - state enum (IDLE/REQ/RSP)
  - owner enum (NONE/IF/D)
  - default ADDR_W/DATA_W localparams
- Sub-module mem_port_arb_sel holds the winner-selection logic plus the streak counter. Inputs: if_req, d_req, grant strobe. Output: sel_d.
- The top level holds the FSM, latches, response routing and perf counters.

## Test plan
- Lone fetch, if_addr=0x0000_0010, mem_gnt immediate, mem_rdata=0x0000_0013 one cycle later -> if_gnt at T, mem_req/mem_addr=0x10 at T+1, if_rvalid with if_rdata=0x13 at T+3. d_rvalid stays 0.
- d_req and if_req both raised at the same time, single transaction -> d_gnt first; mem_we/mem_be track d_we/d_be; if_gnt only after d_rvalid.
- Both requests held continuously, D_STREAK_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; streak resets after each IF.
- mem_gnt delayed 3 cycles -> mem_req and mem_addr held constant for 4 cycles; busy stays high; no extra gnt pulses.
- rst_n asserted while in RSP, then mem_rvalid after reset release -> no x_rvalid; err_unexp pulses once; all outputs at reset values.
- Store d_we=1, d_be=4'b0011, d_wdata=0xDEAD_BEEF -> mem_wdata=0xDEADBEEF, mem_be=0011; d_rvalid one cycle after mem_rvalid. With MEM_PORT_ARB_PERF_EN, perf_d_grants increments by 1.
